// File: rtl/sipo_word_collector_if.sv
// Bus between a word source/frame sink and the serial-in/parallel-out collector.
//   in_valid/in_ready/din : serial word handshake into the collector
//   flush                 : synchronous abort of the frame being built or held
//   out_valid/out_ready   : frame handshake out of the collector
//   dout                  : parallel frame, dout[MEMORY_WID-1] holds the first word received
//   count                 : words held in the current frame, 0..MEMORY_WID
interface sipo_word_collector_if #(
    parameter int unsigned DATA_WID   = 8,
    parameter int unsigned MEMORY_WID = 5
);
    localparam int unsigned CNT_W = $clog2(MEMORY_WID + 1);

    logic                in_valid;
    logic                in_ready;
    logic [DATA_WID-1:0] din;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_WID-1:0] dout [0:MEMORY_WID-1];
    logic [CNT_W-1:0]    count;

    // Source/sink side of the collector
    modport master (
        output in_valid, din, flush, out_ready,
        input  in_ready, out_valid, dout, count
    );

    // Collector side
    modport slave (
        input  in_valid, din, flush, out_ready,
        output in_ready, out_valid, dout, count
    );
endinterface

// File: rtl/sipo_word_collector.sv
// Serial-in/parallel-out word collector. Shifts in one word per accepted
// handshake and presents MEMORY_WID words as one frame with valid/ready.
// Ordering is the inverse of the parallel-to-serial shifter, so loopback
// reproduces the original array.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : collector (slave) side of sipo_word_collector_if
module sipo_word_collector #(
    parameter int unsigned DATA_WID   = 8,
    parameter int unsigned MEMORY_WID = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sipo_word_collector_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(MEMORY_WID + 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_WID-1:0] mem_q [MEMORY_WID];
    logic [DATA_WID-1:0] mem_d [MEMORY_WID];

    logic in_ready_c;
    logic accept_c;
    logic deliver_c;
    logic shift_c;
    logic clear_c;

    // A held frame frees the input only when it is consumed in the same cycle
    assign in_ready_c = (state_q == FILL) || bus.out_ready;
    assign accept_c   = bus.in_valid && in_ready_c;
    assign deliver_c  = (state_q == FULL) && bus.out_ready;

    // Next-state, count and shift/clear controls; flush overrides everything
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shift_c = 1'b0;
        clear_c = 1'b0;
        if (bus.flush) begin
            state_d = FILL;
            count_d = '0;
            clear_c = 1'b1;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (accept_c) begin
                        shift_c = 1'b1;
                        if (count_q == CNT_W'(MEMORY_WID - 1)) begin
                            count_d = CNT_W'(MEMORY_WID);
                            state_d = FULL;
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (deliver_c) begin
                        state_d = FILL;
                        // A word arriving with the delivery starts the next frame
                        if (accept_c) begin
                            shift_c = 1'b1;
                            count_d = CNT_W'(1);
                        end else begin
                            count_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = FILL;
                    count_d = '0;
                end
            endcase
        end
    end

    // Shift register next state: newest word enters at index 0
    always_comb begin
        for (int i = 0; i < int'(MEMORY_WID); i++) begin
            mem_d[i] = mem_q[i];
        end
        if (clear_c) begin
            for (int i = 0; i < int'(MEMORY_WID); i++) begin
                mem_d[i] = '0;
            end
        end else if (shift_c) begin
            mem_d[0] = bus.din;
            for (int i = 1; i < int'(MEMORY_WID); i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end
    end

    // State and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Word storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(MEMORY_WID); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(MEMORY_WID); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Outputs: dout is the storage itself, out_valid is the FULL state
    always_comb begin
        for (int i = 0; i < int'(MEMORY_WID); i++) begin
            bus.dout[i] = mem_q[i];
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == FULL);
    assign bus.count     = count_q;

endmodule

// File: doc/sipo_word_collector.md
Name: sipo_word_collector

Overview:
Serial-in/parallel-out word collector: the receive-side counterpart of the team's parallel-to-serial word shifter. It accepts one DATA_WID-bit word per handshake. After MEMORY_WID words it presents the whole frame as an unpacked word array with a valid/ready handshake. Word ordering is the inverse of the serializer, so serializer-to-collector loopback reproduces the original parallel array.

Parameters:
DATA_WID, 8, width of one word in bits
MEMORY_WID, 5, words per frame; legal range 2..64
CNT_W, $clog2(MEMORY_WID+1), width of the fill counter (derived; do not override)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  din carries a word
in_ready  output  1  collector can accept a word this cycle
din  input  DATA_WID  serial word input
flush  input  1  synchronous abort of the partial or complete frame
out_valid  output  1  dout holds a complete frame
out_ready  input  1  downstream consumes the frame
dout  output  DATA_WID x [0:MEMORY_WID-1]  parallel frame (unpacked array)
count  output  CNT_W  words held in the current frame, 0..MEMORY_WID

Behaviour:
- Reset (async, rst_n low): all Memory words 0, dout all 0, count 0, out_valid 0. Takes effect immediately without a clock edge, including mid-frame or while out_valid=1.
- in_ready = !out_valid || out_ready. Combinational from out_ready; no other comb paths.
- accept = in_valid && in_ready. deliver = out_valid && out_ready.
- dout is the register array Memory directly.
  - Stable and meaningful only while out_valid=1.
  - Contents while out_valid=0 are don't-care to consumers, but deterministic.
- Shift on accept: Memory[0] <= din; Memory[i] <= Memory[i-1] for i = 1..MEMORY_WID-1.
  - First word received ends in dout[MEMORY_WID-1].
  - Last word received ends in dout[0].
- Two states, encoded by out_valid:
  - FILL (out_valid=0):
    - accept with count < MEMORY_WID-1: shift, count+1.
    - accept with count = MEMORY_WID-1: shift, count <= MEMORY_WID, out_valid <= 1 (asserts the cycle after the last accept).
  - FULL (out_valid=1):
    - No deliver: Memory, count and out_valid held; in_ready=0.
    - deliver without accept: out_valid <= 0, count <= 0, Memory unchanged.
    - deliver with accept (same cycle): shift, count <= 1, out_valid <= 0. Zero-bubble back-to-back frames.
- Latency: out_valid rises 1 cycle after the MEMORY_WID-th accept. Sustained throughput is 1 word/cycle with out_ready=1.
- flush (synchronous, highest priority over accept and deliver): count <= 0, out_valid <= 0, Memory <= all 0.
  - A word presented with in_valid in the flush cycle is discarded.
  - A frame pending on out_valid is dropped, even if out_ready=1 in that cycle.
- in_valid=0: no state change except through deliver or flush.
- X on din is only captured on accept; no X is ever written internally.
- count never exceeds MEMORY_WID. No wrap-around: count returns to 0 or 1 only through deliver or flush.

Test Plan:
Use DATA_WID=8, MEMORY_WID=5.
1. Reset release -> out_valid=0, count=0, dout all 0x00, in_ready=1.
2. Words 0x11,0x22,0x33,0x44,0x55 on consecutive cycles, out_ready=0 -> count steps 1..5; out_valid=1 the cycle after 0x55; dout[4..0]=0x11,0x22,0x33,0x44,0x55; in_ready=0.
3. Continue from 2: hold in_valid=1 with din=0x66 and out_ready=0 for 3 cycles -> dout and count stable, in_ready=0. Then out_ready=1 for 1 cycle -> 0x66 accepted that cycle; next cycle out_valid=0, count=1, Memory[0]=0x66.
4. 10 continuous words 0x01..0x0A, out_ready=1 throughout -> in_ready never drops; out_valid high exactly 1 cycle per frame. Frame A: dout[4..0]=0x01..0x05. Frame B: dout[4..0]=0x06..0x0A.
5. Flush scenarios:
   - 3 words, then flush=1 with in_valid=1, din=0xEE -> count=0, 0xEE dropped. Then 0xA1..0xA5 -> clean frame, dout[4..0]=0xA1..0xA5.
   - Flush while out_valid=1 and out_ready=1 -> frame not counted as delivered, out_valid=0.
6. Async reset pulse between clock edges:
   - At count=3 -> count=0 immediately.
   - At out_valid=1 -> out_valid=0 immediately.
   - First frame after release is correct.
